id_ex_pipeline_reg: RTL and testbench

- Pipeline register between instruction decode and execute; latches decoded operands, register addresses, opcode/funct and control bits for the execute-stage ALU control, ALU and forwarding logic.
- Honours the debug unit's step enable; inserts bubbles on load-use stall and clears on branch/jump flush.
- Keeps saturating counters of inserted stall bubbles and flushes for the debug unit.

---
 rtl/id_ex_pipeline_reg.sv | 200 ++++++++++++++++++++
 tb/tb_id_ex_pipeline_reg.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_pipeline_reg.sv
`default_nettype none
// ============================================================================
// Module   : id_ex_pipeline_reg
// Purpose  : ID/EX pipeline register with debug step hold, stall/flush bubbles
//            and saturating bubble/flush event counters.
// Revision : 1.0
// ============================================================================
module id_ex_pipeline_reg #(
  parameter int NB_DATA   = 32,
  parameter int NB_REG    = 5,
  parameter int NB_OPCODE = 6,
  parameter int NB_FCODE  = 6,
  parameter int NB_SHAMT  = 5,
  parameter int NB_CNT    = 8
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_step,
  input  logic                 i_stall,
  input  logic                 i_flush,
  input  logic                 i_valid,
  input  logic [NB_DATA-1:0]   i_pc4,
  input  logic [NB_DATA-1:0]   i_rs_data,
  input  logic [NB_DATA-1:0]   i_rt_data,
  input  logic [NB_DATA-1:0]   i_imm_ext,
  input  logic [NB_REG-1:0]    i_rs_addr,
  input  logic [NB_REG-1:0]    i_rt_addr,
  input  logic [NB_REG-1:0]    i_rd_addr,
  input  logic [NB_SHAMT-1:0]  i_shamt,
  input  logic [NB_FCODE-1:0]  i_funct_code,
  input  logic [NB_OPCODE-1:0] i_opcode,
  input  logic [7:0]           i_ctrl,
  output logic                 o_valid,
  output logic [NB_DATA-1:0]   o_pc4,
  output logic [NB_DATA-1:0]   o_rs_data,
  output logic [NB_DATA-1:0]   o_rt_data,
  output logic [NB_DATA-1:0]   o_imm_ext,
  output logic [NB_REG-1:0]    o_rs_addr,
  output logic [NB_REG-1:0]    o_rt_addr,
  output logic [NB_REG-1:0]    o_rd_addr,
  output logic [NB_SHAMT-1:0]  o_shamt,
  output logic [NB_FCODE-1:0]  o_funct_code,
  output logic [NB_OPCODE-1:0] o_opcode,
  output logic [7:0]           o_ctrl,
  output logic [NB_CNT-1:0]    o_stall_count,
  output logic [NB_CNT-1:0]    o_flush_count
);

  localparam logic [NB_CNT-1:0] CNT_MAX = {NB_CNT{1'b1}};

  typedef enum logic [1:0] {
    ACT_HOLD  = 2'd0,
    ACT_FLUSH = 2'd1,
    ACT_STALL = 2'd2,
    ACT_LOAD  = 2'd3
  } action_e;

  action_e action;

  logic                 valid_q,  valid_d;
  logic [NB_DATA-1:0]   pc4_q,    pc4_d;
  logic [NB_DATA-1:0]   rs_data_q, rs_data_d;
  logic [NB_DATA-1:0]   rt_data_q, rt_data_d;
  logic [NB_DATA-1:0]   imm_q,    imm_d;
  logic [NB_REG-1:0]    rs_addr_q, rs_addr_d;
  logic [NB_REG-1:0]    rt_addr_q, rt_addr_d;
  logic [NB_REG-1:0]    rd_addr_q, rd_addr_d;
  logic [NB_SHAMT-1:0]  shamt_q,  shamt_d;
  logic [NB_FCODE-1:0]  funct_q,  funct_d;
  logic [NB_OPCODE-1:0] opcode_q, opcode_d;
  logic [7:0]           ctrl_q,   ctrl_d;
  logic [NB_CNT-1:0]    stall_cnt_q, stall_cnt_d;
  logic [NB_CNT-1:0]    flush_cnt_q, flush_cnt_d;

  // Flush outranks stall: a flushed instruction is discarded whether or not it
  // would also have been held back by a load-use hazard.
  always_comb begin
    action = ACT_LOAD;
    if (!i_step) begin
      action = ACT_HOLD;
    end else if (i_flush) begin
      action = ACT_FLUSH;
    end else if (i_stall) begin
      action = ACT_STALL;
    end
  end

  always_comb begin
    valid_d   = valid_q;
    pc4_d     = pc4_q;
    rs_data_d = rs_data_q;
    rt_data_d = rt_data_q;
    imm_d     = imm_q;
    rs_addr_d = rs_addr_q;
    rt_addr_d = rt_addr_q;
    rd_addr_d = rd_addr_q;
    shamt_d   = shamt_q;
    funct_d   = funct_q;
    opcode_d  = opcode_q;
    ctrl_d    = ctrl_q;

    unique case (action)
      ACT_HOLD: begin
      end
      ACT_FLUSH, ACT_STALL: begin
        // All-zero bubble decodes as SLL $0 with every write enable low.
        valid_d   = 1'b0;
        pc4_d     = '0;
        rs_data_d = '0;
        rt_data_d = '0;
        imm_d     = '0;
        rs_addr_d = '0;
        rt_addr_d = '0;
        rd_addr_d = '0;
        shamt_d   = '0;
        funct_d   = '0;
        opcode_d  = '0;
        ctrl_d    = '0;
      end
      ACT_LOAD: begin
        valid_d   = i_valid;
        pc4_d     = i_pc4;
        rs_data_d = i_rs_data;
        rt_data_d = i_rt_data;
        imm_d     = i_imm_ext;
        rs_addr_d = i_rs_addr;
        rt_addr_d = i_rt_addr;
        rd_addr_d = i_rd_addr;
        shamt_d   = i_shamt;
        funct_d   = i_funct_code;
        opcode_d  = i_opcode;
        ctrl_d    = i_valid ? i_ctrl : 8'h00;
      end
      default: begin
      end
    endcase
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (action == ACT_STALL && stall_cnt_q != CNT_MAX) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
    if (action == ACT_FLUSH && flush_cnt_q != CNT_MAX) begin
      flush_cnt_d = flush_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      valid_q     <= 1'b0;
      pc4_q       <= '0;
      rs_data_q   <= '0;
      rt_data_q   <= '0;
      imm_q       <= '0;
      rs_addr_q   <= '0;
      rt_addr_q   <= '0;
      rd_addr_q   <= '0;
      shamt_q     <= '0;
      funct_q     <= '0;
      opcode_q    <= '0;
      ctrl_q      <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      valid_q     <= valid_d;
      pc4_q       <= pc4_d;
      rs_data_q   <= rs_data_d;
      rt_data_q   <= rt_data_d;
      imm_q       <= imm_d;
      rs_addr_q   <= rs_addr_d;
      rt_addr_q   <= rt_addr_d;
      rd_addr_q   <= rd_addr_d;
      shamt_q     <= shamt_d;
      funct_q     <= funct_d;
      opcode_q    <= opcode_d;
      ctrl_q      <= ctrl_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign o_valid       = valid_q;
  assign o_pc4         = pc4_q;
  assign o_rs_data     = rs_data_q;
  assign o_rt_data     = rt_data_q;
  assign o_imm_ext     = imm_q;
  assign o_rs_addr     = rs_addr_q;
  assign o_rt_addr     = rt_addr_q;
  assign o_rd_addr     = rd_addr_q;
  assign o_shamt       = shamt_q;
  assign o_funct_code  = funct_q;
  assign o_opcode      = opcode_q;
  assign o_ctrl        = ctrl_q;
  assign o_stall_count = stall_cnt_q;
  assign o_flush_count = flush_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_id_ex_pipeline_reg.sv
`default_nettype none
// ============================================================================
// Module   : tb_id_ex_pipeline_reg
// Purpose  : Self-checking bench for id_ex_pipeline_reg (vector table, corner
//            sequences, randomized run against a behavioural model).
// Revision : 1.0
// ============================================================================
module tb_id_ex_pipeline_reg;

  logic        clk = 1'b0;
  logic        rst, step, stall, flush, valid;
  logic [31:0] pc4, rs_data, rt_data, imm;
  logic [4:0]  rs_addr, rt_addr, rd_addr, shamt;
  logic [5:0]  funct, opcode;
  logic [7:0]  ctrl;

  logic        o_valid;
  logic [31:0] o_pc4, o_rs_data, o_rt_data, o_imm;
  logic [4:0]  o_rs_addr, o_rt_addr, o_rd_addr, o_shamt;
  logic [5:0]  o_funct, o_opcode;
  logic [7:0]  o_ctrl, o_scnt, o_fcnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  id_ex_pipeline_reg dut (
    .i_clk(clk), .i_reset(rst), .i_step(step), .i_stall(stall), .i_flush(flush),
    .i_valid(valid), .i_pc4(pc4), .i_rs_data(rs_data), .i_rt_data(rt_data),
    .i_imm_ext(imm), .i_rs_addr(rs_addr), .i_rt_addr(rt_addr), .i_rd_addr(rd_addr),
    .i_shamt(shamt), .i_funct_code(funct), .i_opcode(opcode), .i_ctrl(ctrl),
    .o_valid(o_valid), .o_pc4(o_pc4), .o_rs_data(o_rs_data), .o_rt_data(o_rt_data),
    .o_imm_ext(o_imm), .o_rs_addr(o_rs_addr), .o_rt_addr(o_rt_addr),
    .o_rd_addr(o_rd_addr), .o_shamt(o_shamt), .o_funct_code(o_funct),
    .o_opcode(o_opcode), .o_ctrl(o_ctrl), .o_stall_count(o_scnt),
    .o_flush_count(o_fcnt)
  );

  // Behavioural model state: what the execute stage should see.
  typedef struct packed {
    logic        valid;
    logic [31:0] pc4, rs, rt, imm;
    logic [4:0]  rsa, rta, rda, shamt;
    logic [5:0]  fn, op;
    logic [7:0]  ctrl, scnt, fcnt;
  } view_t;

  view_t model = '0;
  int    m_stalls = 0;
  int    m_flushes = 0;

  function automatic view_t dut_view();
    view_t v;
    v = {o_valid, o_pc4, o_rs_data, o_rt_data, o_imm, o_rs_addr, o_rt_addr,
         o_rd_addr, o_shamt, o_funct, o_opcode, o_ctrl, o_scnt, o_fcnt};
    return v;
  endfunction

  // Applies the current inputs to the model as an instruction-level event.
  task automatic model_edge();
    if (rst) begin
      model = '0; m_stalls = 0; m_flushes = 0;
    end else if (step) begin
      if (flush || stall) begin
        if (flush) m_flushes = m_flushes + 1;
        else       m_stalls  = m_stalls + 1;
        model = '0;
      end else begin
        model = {valid, pc4, rs_data, rt_data, imm, rs_addr, rt_addr, rd_addr,
                 shamt, funct, opcode, valid ? ctrl : 8'h00, 8'h00, 8'h00};
      end
      model.scnt = 8'(m_stalls > 255 ? 255 : m_stalls);
      model.fcnt = 8'(m_flushes > 255 ? 255 : m_flushes);
    end
  endtask

  task automatic randomize_inputs();
    valid   = ($urandom_range(7) != 0);
    pc4     = $urandom;  rs_data = $urandom;  rt_data = $urandom;  imm = $urandom;
    rs_addr = 5'($urandom); rt_addr = 5'($urandom); rd_addr = 5'($urandom);
    shamt   = 5'($urandom); funct = 6'($urandom); opcode = 6'($urandom);
    ctrl    = 8'($urandom);
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  typedef struct {
    string       name;
    bit          rst, step, stall, flush, valid;
    logic [5:0]  op, fn;
    logic [31:0] rs, rt, imm;
    logic [7:0]  ctrl;
    logic        e_valid;
    logic [5:0]  e_op, e_fn;
    logic [31:0] e_rs, e_rt, e_imm;
    logic [7:0]  e_ctrl, e_sc, e_fc;
  } vec_t;

  vec_t tbl[13];

  function automatic vec_t mk(string n, bit r, bit s, bit st, bit fl, bit v,
                              logic [5:0] op, logic [5:0] fn, logic [31:0] rs,
                              logic [31:0] rt, logic [31:0] im, logic [7:0] c,
                              logic ev, logic [5:0] eop, logic [5:0] efn,
                              logic [31:0] ers, logic [31:0] ert, logic [31:0] eim,
                              logic [7:0] ec, logic [7:0] esc, logic [7:0] efc);
    vec_t x;
    x.name = n; x.rst = r; x.step = s; x.stall = st; x.flush = fl; x.valid = v;
    x.op = op; x.fn = fn; x.rs = rs; x.rt = rt; x.imm = im; x.ctrl = c;
    x.e_valid = ev; x.e_op = eop; x.e_fn = efn; x.e_rs = ers; x.e_rt = ert;
    x.e_imm = eim; x.e_ctrl = ec; x.e_sc = esc; x.e_fc = efc;
    return x;
  endfunction

  initial begin
    //            name        rst st stl fl v  op     fn     rs     rt     imm    ctrl   | ev eop    efn    ers    ert    eimm   ectrl  sc fc
    tbl[0]  = mk("reset0",    1, 1, 1, 1, 1, 6'h23, 6'h2a, 32'hdead, 32'hbeef, 32'h1234, 8'hff, 0, 6'h00, 6'h00, 32'h0, 32'h0, 32'h0, 8'h00, 0, 0);
    tbl[1]  = mk("reset1",    1, 1, 0, 0, 1, 6'h08, 6'h11, 32'h5555, 32'h6666, 32'h7777, 8'h84, 0, 6'h00, 6'h00, 32'h0, 32'h0, 32'h0, 8'h00, 0, 0);
    tbl[2]  = mk("load_add",  0, 1, 0, 0, 1, 6'h00, 6'h20, 32'd5, 32'd7, 32'h0, 8'h81, 1, 6'h00, 6'h20, 32'd5, 32'd7, 32'h0, 8'h81, 0, 0);
    tbl[3]  = mk("load_addi", 0, 1, 0, 0, 1, 6'h08, 6'h00, 32'd9, 32'd3, 32'h4, 8'h84, 1, 6'h08, 6'h00, 32'd9, 32'd3, 32'h4, 8'h84, 0, 0);
    tbl[4]  = mk("hold0",     0, 0, 0, 1, 1, 6'h23, 6'h01, 32'hA1, 32'hB1, 32'hC1, 8'hd4, 1, 6'h08, 6'h00, 32'd9, 32'd3, 32'h4, 8'h84, 0, 0);
    tbl[5]  = mk("hold1",     0, 0, 1, 1, 0, 6'h2b, 6'h02, 32'hA2, 32'hB2, 32'hC2, 8'h24, 1, 6'h08, 6'h00, 32'd9, 32'd3, 32'h4, 8'h84, 0, 0);
    tbl[6]  = mk("hold2",     0, 0, 0, 1, 1, 6'h04, 6'h03, 32'hA3, 32'hB3, 32'hC3, 8'hff, 1, 6'h08, 6'h00, 32'd9, 32'd3, 32'h4, 8'h84, 0, 0);
    tbl[7]  = mk("load_lw",   0, 1, 0, 0, 1, 6'h23, 6'h00, 32'h100, 32'h0, 32'h8, 8'hd4, 1, 6'h23, 6'h00, 32'h100, 32'h0, 32'h8, 8'hd4, 0, 0);
    tbl[8]  = mk("stall",     0, 1, 1, 0, 1, 6'h00, 6'h20, 32'd1, 32'd2, 32'h0, 8'h81, 0, 6'h00, 6'h00, 32'h0, 32'h0, 32'h0, 8'h00, 1, 0);
    tbl[9]  = mk("load_sw",   0, 1, 0, 0, 1, 6'h2b, 6'h00, 32'h200, 32'h77, 32'hc, 8'h24, 1, 6'h2b, 6'h00, 32'h200, 32'h77, 32'hc, 8'h24, 1, 0);
    tbl[10] = mk("flush_stl", 0, 1, 1, 1, 1, 6'h23, 6'h00, 32'd4, 32'd4, 32'h4, 8'hd4, 0, 6'h00, 6'h00, 32'h0, 32'h0, 32'h0, 8'h00, 1, 1);
    tbl[11] = mk("invalid",   0, 1, 0, 0, 0, 6'h04, 6'h05, 32'h11, 32'h22, 32'h33, 8'hff, 0, 6'h04, 6'h05, 32'h11, 32'h22, 32'h33, 8'h00, 1, 1);
    tbl[12] = mk("hold_stl",  0, 0, 1, 0, 1, 6'h00, 6'h00, 32'h0, 32'h0, 32'h0, 8'hff, 0, 6'h04, 6'h05, 32'h11, 32'h22, 32'h33, 8'h00, 1, 1);

    rst = 1'b1; step = 1'b1; stall = 1'b0; flush = 1'b0;
    randomize_inputs();
    #1;

    foreach (tbl[k]) begin
      randomize_inputs();
      rst = tbl[k].rst; step = tbl[k].step; stall = tbl[k].stall; flush = tbl[k].flush;
      valid = tbl[k].valid; opcode = tbl[k].op; funct = tbl[k].fn;
      rs_data = tbl[k].rs; rt_data = tbl[k].rt; imm = tbl[k].imm; ctrl = tbl[k].ctrl;
      tick();
      check(tbl[k].name,
            {o_valid, o_opcode, o_funct, o_rs_data, o_rt_data, o_imm, o_ctrl, o_scnt, o_fcnt},
            {tbl[k].e_valid, tbl[k].e_op, tbl[k].e_fn, tbl[k].e_rs, tbl[k].e_rt,
             tbl[k].e_imm, tbl[k].e_ctrl, tbl[k].e_sc, tbl[k].e_fc});
      if (k == 1 || k == 8) check({tbl[k].name, "_full"}, dut_view(), model);
    end

    // Stall counter saturation; counter starts this sequence at 1.
    rst = 1'b0; step = 1'b1; stall = 1'b1; flush = 1'b0;
    for (int n = 1; n <= 300; n++) begin
      randomize_inputs();
      tick();
      if (n == 100 || n == 254 || n == 255 || n == 300)
        check("stall_sat_seq", o_scnt, (n + 1 > 255) ? 255 : n + 1);
    end
    step = 1'b0;
    tick();
    check("stall_sat_hold", o_scnt, 8'd255);
    step = 1'b1; rst = 1'b1;
    tick();
    check("stall_sat_reset", {o_scnt, o_fcnt, o_valid}, 17'd0);
    rst = 1'b0;
    tick();
    check("stall_after_reset", o_scnt, 8'd1);

    // Flush counter saturation with stall also asserted.
    flush = 1'b1;
    for (int n = 0; n < 260; n++) begin
      randomize_inputs();
      tick();
    end
    check("flush_sat", o_fcnt, 8'd255);
    check("flush_sat_scnt", o_scnt, 8'd1);
    check("flush_sat_full", dut_view(), model);

    // Randomized run against the model, with occasional resets.
    for (int n = 0; n < 3000; n++) begin
      randomize_inputs();
      rst   = ($urandom_range(99) == 0);
      step  = ($urandom_range(3) != 0);
      stall = ($urandom_range(3) == 0);
      flush = ($urandom_range(7) == 0);
      tick();
      check("random", dut_view(), model);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
